shift_stage: RTL and testbench

Pipelined shift execution stage for the ALU. It accepts decoded shift operations from the issue stage with a valid/ready handshake and latches the operands. It drives the 32-bit barrel shifter (mshifter32) from that operand register and captures the shifter output in a result register. The result is presented to writeback with its own valid/ready handshake.

---
 rtl/shift_stage.sv | 147 ++++++++++++++
 tb/tb_shift_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - two-register pipelined shift execution stage
//
// mshifter32: combinational 32-bit barrel shifter, five mux levels.
//   data     in  32  value to shift
//   shiftby  in   5  shift amount
//   shiftdir in   1  0 = left, 1 = right
//   shifta   in   1  arithmetic fill for right shifts
//   result   out 32  shifted value
//
// shift_stage: issue -> operand register -> shifter -> result register -> writeback.
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         synchronous kill of both pipeline registers
//   in_valid/in_ready             issue handshake (in_ready is combinational)
//   in_op, in_rs, in_rt,
//   in_shamt, in_rd               decoded shift operation
//   out_valid/out_ready           writeback handshake
//   out_result, out_rd,
//   out_illegal                   registered result fields

module mshifter32 (
    input  logic [31:0] data,
    input  logic [4:0]  shiftby,
    input  logic        shiftdir,
    input  logic        shifta,
    output logic [31:0] result
);

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    logic        fill;
    logic [31:0] x;

    // Left shifts reuse the right-shift network on bit-reversed data, so
    // only one five-level mux chain exists.
    always_comb begin
        fill = shifta & shiftdir & data[31];
        x    = shiftdir ? data : bit_rev(data);
        if (shiftby[0]) x = {fill, x[31:1]};
        if (shiftby[1]) x = {{2{fill}}, x[31:2]};
        if (shiftby[2]) x = {{4{fill}}, x[31:4]};
        if (shiftby[3]) x = {{8{fill}}, x[31:8]};
        if (shiftby[4]) x = {{16{fill}}, x[31:16]};
        result = shiftdir ? x : bit_rev(x);
    end

endmodule

module shift_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [31:0] s1_rt;
    logic [4:0]  s1_amount;
    logic [4:0]  s1_rd;

    logic        s2_valid;
    logic [31:0] s2_result;
    logic [4:0]  s2_rd;
    logic        s2_illegal;

    logic        adv2;
    logic        in_illegal;
    logic [4:0]  in_amount;
    logic        s1_illegal;
    logic [31:0] sh_result;

    assign adv2     = !s2_valid || out_ready;
    assign in_ready = !s1_valid || adv2;

    // Opcodes x01 are illegal; their amount is forced to zero so the shifter
    // passes rt through untouched (op[1]=0 also selects a left shift).
    assign in_illegal = (in_op[1:0] == 2'b01);
    assign in_amount  = in_illegal ? 5'd0 : (in_op[2] ? in_rs[4:0] : in_shamt);
    assign s1_illegal = (s1_op[1:0] == 2'b01);

    mshifter32 u_shifter (
        .data     (s1_rt),
        .shiftby  (s1_amount),
        .shiftdir (s1_op[1]),
        .shifta   (s1_op[1] & s1_op[0]),
        .result   (sh_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= 3'd0;
            s1_rt      <= 32'd0;
            s1_amount  <= 5'd0;
            s1_rd      <= 5'd0;
            s2_valid   <= 1'b0;
            s2_result  <= 32'd0;
            s2_rd      <= 5'd0;
            s2_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result  <= sh_result;
                    s2_rd      <= s1_rd;
                    s2_illegal <= s1_illegal;
                end
            end
            // in_ready already accounts for stage 1 draining on this edge.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op     <= in_op;
                    s1_rt     <= in_rt;
                    s1_amount <= in_amount;
                    s1_rd     <= in_rd;
                end
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_rd      = s2_rd;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_shift_stage.sv
// tb/tb_shift_stage.sv - directed vector bench for shift_stage

module tb_shift_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_shamt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    shift_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_shamt   (in_shamt),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [31:0] exp_result;
        logic        exp_illegal;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int n_applied;
    int n_miscompares;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] shamt, input logic [4:0] rd);
        in_valid = v;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_shamt = shamt;
        in_rd    = rd;
    endtask

    task automatic check_out(input string name, input logic [31:0] res, input logic [4:0] rd,
                             input logic ill);
        check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({name, ".result"}, out_result, res);
        check({name, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
        check({name, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;

        //          op      rs            rt            shamt  rd     result        ill
        vecs[0]  = '{3'b000, 32'h0000_0003, 32'h0000_0001, 5'd31, 5'd1,  32'h8000_0000, 1'b0};
        vecs[1]  = '{3'b010, 32'h0000_0007, 32'h8000_0000, 5'd4,  5'd2,  32'h0800_0000, 1'b0};
        vecs[2]  = '{3'b011, 32'h0000_0000, 32'h8000_0000, 5'd4,  5'd3,  32'hF800_0000, 1'b0};
        vecs[3]  = '{3'b111, 32'hFFFF_FFE4, 32'hF000_000F, 5'd31, 5'd4,  32'hFF00_0000, 1'b0};
        vecs[4]  = '{3'b100, 32'h0000_0020, 32'h0000_0001, 5'd9,  5'd5,  32'h0000_0001, 1'b0};
        vecs[5]  = '{3'b101, 32'h0000_0003, 32'h1234_5678, 5'd7,  5'd6,  32'h1234_5678, 1'b1};
        vecs[6]  = '{3'b110, 32'h0000_001F, 32'hF000_0000, 5'd2,  5'd7,  32'h0000_0001, 1'b0};
        vecs[7]  = '{3'b011, 32'hFFFF_FFFF, 32'h7FFF_0000, 5'd16, 5'd8,  32'h0000_7FFF, 1'b0};
        vecs[8]  = '{3'b001, 32'h0000_0004, 32'hDEAD_BEEF, 5'd5,  5'd9,  32'hDEAD_BEEF, 1'b1};
        vecs[9]  = '{3'b000, 32'h0000_0011, 32'hDEAD_BEEF, 5'd0,  5'd10, 32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{3'b100, 32'h0000_0008, 32'h0000_FFFF, 5'd3,  5'd11, 32'h00FF_FF00, 1'b0};
        vecs[11] = '{3'b111, 32'h0000_001F, 32'hFFFF_FFFF, 5'd0,  5'd31, 32'hFFFF_FFFF, 1'b0};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0);

        // Reset state
        @(negedge clk);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_result", out_result, 32'd0);
        check("rst.out_rd", {27'd0, out_rd}, 32'd0);
        check("rst.out_illegal", {31'd0, out_illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream; vector k is visible at the negedge two edges later.
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            check("stream.in_ready", {31'd0, in_ready}, 32'd1);
            if (k >= 2)
                check_out($sformatf("vec%0d", k - 2), vecs[k-2].exp_result, vecs[k-2].rd,
                          vecs[k-2].exp_illegal);
            if (k < NV)
                drive(1'b1, vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].shamt, vecs[k].rd);
            else
                drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        end
        @(negedge clk);
        check("stream.drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: three ops with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, vecs[0].op, vecs[0].rs, vecs[0].rt, vecs[0].shamt, vecs[0].rd);
        @(negedge clk);
        check("bp.ready_after_1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, vecs[1].op, vecs[1].rs, vecs[1].rt, vecs[1].shamt, vecs[1].rd);
        @(negedge clk);
        check("bp.ready_after_2", {31'd0, in_ready}, 32'd0);
        drive(1'b1, vecs[2].op, vecs[2].rs, vecs[2].rt, vecs[2].shamt, vecs[2].rd);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.hold_ready", {31'd0, in_ready}, 32'd0);
            check_out("bp.hold", vecs[0].exp_result, vecs[0].rd, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.ready_on_release", {31'd0, in_ready}, 32'd1);
        check_out("bp.first", vecs[0].exp_result, vecs[0].rd, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        check_out("bp.second", vecs[1].exp_result, vecs[1].rd, 1'b0);
        @(negedge clk);
        check_out("bp.third", vecs[2].exp_result, vecs[2].rd, 1'b0);
        @(negedge clk);
        check("bp.no_dup", {31'd0, out_valid}, 32'd0);

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        drive(1'b1, vecs[3].op, vecs[3].rs, vecs[3].rt, vecs[3].shamt, vecs[3].rd);
        @(negedge clk);
        drive(1'b1, vecs[4].op, vecs[4].rs, vecs[4].rt, vecs[4].shamt, vecs[4].rd);
        @(negedge clk);
        check("flush.pre_full", {31'd0, out_valid}, 32'd1);
        drive(1'b1, vecs[5].op, vecs[5].rs, vecs[5].rt, vecs[5].shamt, vecs[5].rd);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush.no_emit", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset between edges, mid-stream.
        drive(1'b1, vecs[2].op, vecs[2].rs, vecs[2].rt, vecs[2].shamt, vecs[2].rd);
        @(negedge clk);
        drive(1'b1, vecs[7].op, vecs[7].rs, vecs[7].rt, vecs[7].shamt, vecs[7].rd);
        @(negedge clk);
        check_out("arst.pre", vecs[2].exp_result, vecs[2].rd, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.out_result", out_result, 32'd0);
        check("arst.out_rd", {27'd0, out_rd}, 32'd0);
        check("arst.in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        drive(1'b1, vecs[10].op, vecs[10].rs, vecs[10].rt, vecs[10].shamt, vecs[10].rd);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        check("arst.latency", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_out("arst.resume", vecs[10].exp_result, vecs[10].rd, 1'b0);
        @(negedge clk);
        check("arst.end", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
